snake_step_ctrl: RTL and testbench

- Game-level controller that sequences the snake segment array.
- Generates the step strobe and the committed travel direction, owns the snake size and score, and issues segment (re)initialisation.
- Detects game over from the OR of all segment hit flags.
- Sits between the button/apple logic and the array of segment cells; every segment shares its next_dir, size and seg_reset outputs.

---
 rtl/snake_step_ctrl.sv | 120 ++++++++++++
 tb/tb_snake_step_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_step_ctrl.sv
// Game-level sequencer for the snake segment array: step strobe, committed
// direction, size/score bookkeeping, segment initialisation and game-over detection.
module snake_step_ctrl #(
   parameter int unsigned STEP_TICKS = 256,
   parameter int unsigned INIT_SIZE  = 3,
   parameter int unsigned MAX_SIZE   = 63,
   parameter logic [1:0]  DIR_INIT   = 2'b01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] dir_req,
   input  logic       apple_eaten,
   input  logic       hit_any,
   output logic [1:0] next_dir,
   output logic [5:0] size,
   output logic       step,
   output logic       seg_reset,
   output logic       running,
   output logic       game_over,
   output logic [7:0] score
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OVER} state_t;

   localparam logic [7:0] TICK_LAST = 8'(STEP_TICKS - 1);
   localparam logic [5:0] SIZE_INIT = 6'(INIT_SIZE);
   localparam logic [5:0] SIZE_MAX  = 6'(MAX_SIZE);

   state_t     state, state_nxt;
   logic [7:0] tick;
   logic [1:0] pending_dir;
   logic [1:0] req_dir;
   logic       req_valid;

   // Lowest set request bit wins.
   always_comb begin
      req_valid = |dir_req;
      req_dir   = '0;
      priority casez (dir_req)
         4'b???1: req_dir = 2'd0;
         4'b??10: req_dir = 2'd1;
         4'b?100: req_dir = 2'd2;
         4'b1000: req_dir = 2'd3;
         default: req_dir = 2'd0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      seg_reset = 1'b0;
      running   = 1'b0;
      game_over = 1'b0;
      case (state)
         IDLE: begin
            seg_reset = 1'b1;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            seg_reset = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            running = 1'b1;
            if (hit_any) state_nxt = OVER;
         end
         OVER: begin
            game_over = 1'b1;
            if (start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         next_dir    <= DIR_INIT;
         pending_dir <= DIR_INIT;
         size        <= SIZE_INIT;
         score       <= '0;
         tick        <= '0;
         step        <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            LOAD: begin
               next_dir    <= DIR_INIT;
               pending_dir <= DIR_INIT;
               size        <= SIZE_INIT;
               score       <= '0;
               tick        <= '0;
            end
            RUN: begin
               // A hit suppresses the step, the commit, the capture and the growth.
               if (!hit_any) begin
                  if (tick == TICK_LAST) begin
                     tick     <= '0;
                     step     <= 1'b1;
                     next_dir <= pending_dir;
                  end else begin
                     tick <= tick + 8'd1;
                  end
                  if (req_valid && (req_dir != ~next_dir)) pending_dir <= req_dir;
                  if (apple_eaten) begin
                     if (size < SIZE_MAX) size <= size + 6'd1;
                     if (score != 8'hFF)  score <= score + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Self-checking bench for snake_step_ctrl: directed scenarios plus random play,
// compared every cycle against a behavioural game model.
module tb_snake_step_ctrl;

   localparam int ST    = 4;
   localparam int ISIZE = 3;
   localparam int MSIZE = 7;

   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_OVER = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] dir_req = 4'b0000;
   logic       apple_eaten = 1'b0;
   logic       hit_any = 1'b0;
   logic [1:0] next_dir;
   logic [5:0] size;
   logic       step;
   logic       seg_reset;
   logic       running;
   logic       game_over;
   logic [7:0] score;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   int m_mode, m_dir, m_pend, m_size, m_score, m_runs, m_step;

   snake_step_ctrl #(
      .STEP_TICKS(ST),
      .INIT_SIZE (ISIZE),
      .MAX_SIZE  (MSIZE),
      .DIR_INIT  (2'b01)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .dir_req    (dir_req),
      .apple_eaten(apple_eaten),
      .hit_any    (hit_any),
      .next_dir   (next_dir),
      .size       (size),
      .step       (step),
      .seg_reset  (seg_reset),
      .running    (running),
      .game_over  (game_over),
      .score      (score)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      int new_dir;
      int req;
      if (!reset) begin
         m_mode = M_IDLE; m_dir = 1; m_pend = 1;
         m_size = ISIZE; m_score = 0; m_runs = 0; m_step = 0;
         return;
      end
      m_step = 0;
      case (m_mode)
         M_IDLE: if (start) m_mode = M_LOAD;
         M_LOAD: begin
            m_size = ISIZE; m_score = 0; m_runs = 0;
            m_dir = 1; m_pend = 1; m_mode = M_RUN;
         end
         M_RUN: begin
            if (hit_any) m_mode = M_OVER;
            else begin
               m_runs++;
               new_dir = m_dir;
               if (m_runs % ST == 0) begin
                  m_step  = 1;
                  new_dir = m_pend;
               end
               req = -1;
               for (int i = 3; i >= 0; i--) if (dir_req[i]) req = i;
               if (req >= 0 && req != (3 - m_dir)) m_pend = req;
               m_dir = new_dir;
               if (apple_eaten) begin
                  if (m_size < MSIZE) m_size++;
                  if (m_score < 255) m_score++;
               end
            end
         end
         default: if (start) m_mode = M_LOAD;
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      chk("next_dir",  8'(next_dir),  8'(m_dir));
      chk("size",      8'(size),      8'(m_size));
      chk("score",     score,         8'(m_score));
      chk("step",      8'(step),      8'(m_step));
      chk("seg_reset", 8'(seg_reset), 8'((m_mode == M_IDLE || m_mode == M_LOAD) ? 1 : 0));
      chk("running",   8'(running),   8'((m_mode == M_RUN) ? 1 : 0));
      chk("game_over", 8'(game_over), 8'((m_mode == M_OVER) ? 1 : 0));
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Advance until the model's tick phase equals t (bounded).
   task automatic to_tick(input int t);
      for (int k = 0; k < 4 * ST; k++) begin
         if (m_mode == M_RUN && (m_runs % ST) == t) return;
         cycle();
      end
      n_cmp++; n_bad++;
      $error("FAIL to_tick observed=timeout expected=tick%0d", t);
   endtask

   task automatic begin_game();
      start = 1'b1; cycle(); start = 1'b0;
      cycle();
   endtask

   initial begin
      // 1. reset, idle, start and step cadence
      reset = 1'b0;
      run_n(2);
      reset = 1'b1;
      run_n(3);
      chk("idle_size", 8'(size), 8'(ISIZE));
      chk("idle_dir",  8'(next_dir), 8'h01);
      start = 1'b1; cycle(); start = 1'b0;
      chk("load_segrst", 8'(seg_reset), 8'h01);
      run_n(1 + 2 * ST + 1);

      // 2. reversal rejection and same-interval overwrite
      dir_req = 4'b0100; run_n(ST + 1); dir_req = 4'b0000;
      run_n(ST);
      dir_req = 4'b0001; run_n(1); dir_req = 4'b0000;
      run_n(ST + 1);
      to_tick(1);
      dir_req = 4'b1000; cycle();
      dir_req = 4'b0010; cycle();
      dir_req = 4'b0000;
      run_n(ST + 1);
      chk("dir_after_pair", 8'(next_dir), 8'h01);
      // request landing exactly on the commit cycle
      to_tick(ST - 1);
      dir_req = 4'b1001; cycle(); dir_req = 4'b0000;
      run_n(ST + 1);

      // 3. growth saturation and score saturation
      apple_eaten = 1'b1; run_n(6); apple_eaten = 1'b0;
      chk("size_sat", 8'(size), 8'(MSIZE));
      apple_eaten = 1'b1; run_n(260); apple_eaten = 1'b0;
      chk("score_sat", score, 8'hFF);

      // 4. hit with apple on the commit cycle
      dir_req = 4'b0001; cycle(); dir_req = 4'b0000;
      to_tick(ST - 1);
      hit_any = 1'b1; apple_eaten = 1'b1; cycle();
      hit_any = 1'b0;
      chk("hit_step", 8'(step), 8'h00);
      dir_req = 4'b0100; hit_any = 1'b1; run_n(6);
      apple_eaten = 1'b0; dir_req = 4'b0000; hit_any = 1'b0;

      // 5. restart from OVER
      begin_game();
      chk("restart_score", score, 8'h00);
      run_n(3);

      // 6. reset mid-run at tick 2 with size 7
      apple_eaten = 1'b1; run_n(4); apple_eaten = 1'b0;
      to_tick(2);
      reset = 1'b0; cycle(); reset = 1'b1;
      chk("rst_size", 8'(size), 8'(ISIZE));
      run_n(2);

      // random play
      for (int k = 0; k < 1500; k++) begin
         reset       = ($urandom_range(0, 199) != 0);
         start       = ($urandom_range(0, 19) == 0);
         hit_any     = ($urandom_range(0, 59) == 0);
         apple_eaten = ($urandom_range(0, 3) == 0);
         dir_req     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
